// File: rtl/us_pkg.sv
// Shared definitions for the ultrasonic ranging path: FSM state encoding and
// default timing constants (50 MHz clock) used by the emulator and benches.
package us_pkg;

    // Responder states. IDLE waits for a trigger, TRIG_HI measures its width,
    // DELAY stands in for the 40 kHz burst, ECHO drives the echo pulse.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TRIG_HI = 2'd1,
        ST_DELAY   = 2'd2,
        ST_ECHO    = 2'd3
    } us_state_e;

    localparam int TRIG_MIN_CYCLES    = 500;      // 10 us minimum trigger
    localparam int BURST_DELAY_CYCLES = 12500;    // 250 us trigger-fall to echo-rise
    localparam int CYCLES_PER_CM      = 2900;     // 58 us of echo per centimetre
    localparam int NO_OBJ_CYCLES      = 1900000;  // 38 ms no-object timeout

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for bringing an asynchronous level into the
// clock domain. Both stages clear to 0 on synchronous reset.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_d, meta_q;
    logic [W-1:0] sync_d, sync_q;

    // Next values: first stage samples the raw input, second stage the first.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/us_echo_emulator.sv
// Ultrasonic sensor emulator: measures the trigger pulse from the ranging
// controller and, for a valid trigger, answers with an echo pulse whose
// width encodes distance_cm (or the no-object timeout when it is 0).
// One down-counter is shared by the trigger-width, burst-delay and echo
// phases; the distance multiply happens once, when the trigger is accepted.
module us_echo_emulator #(
    parameter int TRIG_MIN_CYCLES    = us_pkg::TRIG_MIN_CYCLES,
    parameter int BURST_DELAY_CYCLES = us_pkg::BURST_DELAY_CYCLES,
    parameter int CYCLES_PER_CM      = us_pkg::CYCLES_PER_CM,
    parameter int NO_OBJ_CYCLES      = us_pkg::NO_OBJ_CYCLES,
    parameter int CNT_W              = 21
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             trig,
    input  logic [5:0]       distance_cm,
    output logic             echo,
    output logic             busy,
    output logic [7:0]       meas_count,
    output us_pkg::us_state_e dbg_state
);

    import us_pkg::*;

    typedef logic [CNT_W-1:0] cnt_t;

    // Counter load values. Each phase loads N-1 and finishes on the cycle the
    // counter reads zero, so a phase of N cycles ends exactly N edges later.
    // The trigger load accounts for the IDLE cycle that first saw trig_s high.
    localparam cnt_t TRIG_LOAD  = cnt_t'(TRIG_MIN_CYCLES - 1);
    localparam cnt_t DELAY_LOAD = cnt_t'(BURST_DELAY_CYCLES - 1);
    localparam cnt_t NO_OBJ_LEN = cnt_t'(NO_OBJ_CYCLES);
    localparam cnt_t PER_CM     = cnt_t'(CYCLES_PER_CM);
    localparam cnt_t ONE        = cnt_t'(1);

    logic      trig_s;
    us_state_e state_d, state_q;
    cnt_t      cnt_d, cnt_q;
    cnt_t      echo_len_d, echo_len_q;
    cnt_t      dist_len;
    logic      echo_d, echo_q;
    logic      busy_d, busy_q;
    logic [7:0] meas_count_d, meas_count_q;

    sync2 #(.W(1)) u_trig_sync (
        .clk (clock),
        .rst (reset),
        .d   (trig),
        .q   (trig_s)
    );

    // Echo length for a non-zero distance; parameters guarantee it fits CNT_W.
    assign dist_len = cnt_t'(distance_cm) * PER_CM;

    // Next-state and output logic for the trigger/delay/echo sequence.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        echo_len_d   = echo_len_q;
        echo_d       = echo_q;
        busy_d       = busy_q;
        meas_count_d = meas_count_q;
        case (state_q)
            ST_IDLE: begin
                if (trig_s) begin
                    state_d = ST_TRIG_HI;
                    cnt_d   = TRIG_LOAD;
                end
            end
            ST_TRIG_HI: begin
                if (trig_s) begin
                    // Saturate at zero: long triggers are simply valid.
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - ONE;
                    end
                end else if (cnt_q == '0) begin
                    state_d    = ST_DELAY;
                    cnt_d      = DELAY_LOAD;
                    busy_d     = 1'b1;
                    echo_len_d = (distance_cm == 6'd0) ? NO_OBJ_LEN : dist_len;
                end else begin
                    // Runt trigger: drop it silently.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_DELAY: begin
                if (cnt_q == '0) begin
                    state_d = ST_ECHO;
                    echo_d  = 1'b1;
                    cnt_d   = echo_len_q - ONE;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            ST_ECHO: begin
                if (cnt_q == '0) begin
                    state_d      = ST_IDLE;
                    echo_d       = 1'b0;
                    busy_d       = 1'b0;
                    meas_count_d = meas_count_q + 8'd1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs; reset truncates any pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            echo_len_q   <= '0;
            echo_q       <= 1'b0;
            busy_q       <= 1'b0;
            meas_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            echo_len_q   <= echo_len_d;
            echo_q       <= echo_d;
            busy_q       <= busy_d;
            meas_count_q <= meas_count_d;
        end
    end

    assign echo       = echo_q;
    assign busy       = busy_q;
    assign meas_count = meas_count_q;
    assign dbg_state  = state_q;

endmodule
